// File: rtl/pipelined_shifter_if.sv
// Bus interface for pipelined_shifter: operand/result handshake plus flush.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high on that channel. The producer holds valid and payload steady until
// the transfer; ready may be computed combinationally and never waits on
// valid. flush travels with the producer side and squashes in-flight work.
interface pipelined_shifter_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_mode;
   logic [TAG_W-1:0]   in_tag;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [TAG_W-1:0]   out_tag;

   // Producer/consumer side of the shifter.
   modport master (
      output in_valid, in_data, in_shamt, in_mode, in_tag, flush, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   // The shifter itself.
   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, in_tag, flush, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one binary-weighted stage per
// shift-amount bit, each followed by a register. Latency is log2(WIDTH)
// cycles, throughput one operation per cycle, global stall on backpressure.
module pipelined_shifter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_shifter_if.slave   bus
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int N       = SHAMT_W;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;

   // Stage registers: stage N-1 is the output stage.
   logic               vldQ   [N];
   logic [WIDTH-1:0]   dataQ  [N];
   logic [SHAMT_W-1:0] shamtQ [N];
   logic [1:0]         modeQ  [N];
   logic               signQ  [N];
   logic [TAG_W-1:0]   tagQ   [N];

   // Values presented to each stage before its shift.
   logic               srcVld   [N];
   logic [WIDTH-1:0]   srcData  [N];
   logic [SHAMT_W-1:0] srcShamt [N];
   logic [1:0]         srcMode  [N];
   logic               srcSign  [N];
   logic [TAG_W-1:0]   srcTag   [N];
   logic [WIDTH-1:0]   shifted  [N];

   logic adv;
   logic inReady;

   // One fixed-distance shift; SRA fill comes from the sign captured at
   // accept, so it stays correct however many stages have already shifted.
   function automatic logic [WIDTH-1:0] shiftBy(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       m,
      input logic             s,
      input int               amt
   );
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] fill;
      fill = s ? ~({WIDTH{1'b1}} >> amt) : '0;
      case (m)
         MODE_SLL: res = d << amt;
         MODE_SRL: res = d >> amt;
         MODE_SRA: res = (d >> amt) | fill;
         default:  res = (d >> amt) | (d << (WIDTH - amt));
      endcase
      return res;
   endfunction

   // Global stall: the whole pipe moves only when the output slot frees up.
   assign adv     = !vldQ[N-1] || bus.out_ready;
   assign inReady = adv && !bus.flush;

   assign bus.in_ready  = inReady;
   assign bus.out_valid = vldQ[N-1];
   assign bus.out_data  = dataQ[N-1];
   assign bus.out_tag   = tagQ[N-1];

   // Route each stage's source (input port or previous register) and apply
   // that stage's 2^k shift when its shamt bit is set.
   always_comb begin
      srcVld[0]   = bus.in_valid && inReady;
      srcData[0]  = bus.in_data;
      srcShamt[0] = bus.in_shamt;
      srcMode[0]  = bus.in_mode;
      srcSign[0]  = bus.in_data[WIDTH-1];
      srcTag[0]   = bus.in_tag;
      for (int k = 1; k < N; k++) begin
         srcVld[k]   = vldQ[k-1];
         srcData[k]  = dataQ[k-1];
         srcShamt[k] = shamtQ[k-1];
         srcMode[k]  = modeQ[k-1];
         srcSign[k]  = signQ[k-1];
         srcTag[k]   = tagQ[k-1];
      end
      for (int k = 0; k < N; k++) begin
         shifted[k] = srcShamt[k][k] ? shiftBy(srcData[k], srcMode[k], srcSign[k], 1 << k)
                                     : srcData[k];
      end
   end

   // Pipeline registers: flush kills all valid bits even while stalled;
   // payload only moves on advance and may stay stale under a cleared valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            vldQ[k]   <= 1'b0;
            dataQ[k]  <= '0;
            shamtQ[k] <= '0;
            modeQ[k]  <= '0;
            signQ[k]  <= 1'b0;
            tagQ[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (bus.flush) begin
               vldQ[k] <= 1'b0;
            end else if (adv) begin
               vldQ[k] <= srcVld[k];
            end
            if (adv) begin
               dataQ[k]  <= shifted[k];
               shamtQ[k] <= srcShamt[k];
               modeQ[k]  <= srcMode[k];
               signQ[k]  <= srcSign[k];
               tagQ[k]   <= srcTag[k];
            end
         end
      end
   end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the combinational 32-bit SLL shifter in the execute path.
- Supports four modes: SLL, SRL, SRA and ROR, at a power-of-two data width.
- Each binary-weighted shift stage is followed by a pipeline register, giving a fixed latency of log2(WIDTH) cycles.
- Carries a destination tag alongside the data, has a valid/ready handshake with global stall, and a flush input for branch squash.

Parameters:
- WIDTH, 32, data width; must be a power of two, >= 4.
- TAG_W, 5, width of the sideband tag (destination register number).
- SHAMT_W, clog2(WIDTH), derived localparam (not overridable); shift-amount width and the pipeline depth N.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input operation present.
- in_ready  output  1  block accepts the input this cycle.
- in_data  input  WIDTH  operand to shift.
- in_shamt  input  SHAMT_W  shift amount.
- in_mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- flush  input  1  squash all in-flight operations.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst=1): all stage valid bits, data, shamt, mode, tag and sign registers clear to 0. Outputs: out_valid=0, out_data=0, out_tag=0. Reset mid-operation discards all in-flight work; in_ready depends only on flush and the advance condition.
- Pipeline:
  - Stage k (k=0..N-1) shifts by 2^k when shamt bit k is set, then registers the result.
  - Each stage register holds valid, data, remaining shamt, mode, sign and tag.
  - Latency is exactly N cycles from accept to out_valid when there is no stall (WIDTH=32 gives 5).
  - Throughput is 1 operation per cycle.
- Advance condition: adv = !out_valid || out_ready.
  - When adv=1, every stage register loads from the stage before it; stage 0 loads the input (valid = in_valid && in_ready).
  - When adv=0, all stage registers hold. This is a global stall; bubbles are not collapsed.
- in_ready = adv && !flush. Combinational; it does not depend on in_valid.
- Output handshake: out_valid, out_data and out_tag stay stable while out_valid && !out_ready. A transfer occurs when out_valid && out_ready.
- Modes:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the sign bit of the original in_data. The sign is captured at accept and piped along with the data.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
  - shamt=0 gives the unmodified operand in every mode.
- Flush:
  - When flush=1 at a clock edge, all stage valid bits clear, including the output stage, even if out_ready=0.
  - No input is accepted that cycle (in_ready=0).
  - Data and tag registers may keep stale values; out_data is don't-care while out_valid=0.
- Simultaneous events:
  - flush together with in_valid: flush wins and the input is dropped.
  - flush together with an output transfer (out_valid && out_ready): the transfer counts as completed, then the pipeline empties.
- Mode and shamt are sampled only at accept; later changes to the input ports do not affect in-flight operations.
- Tag is never modified.

Test Plan:
- Basic SLL (WIDTH=32): in_data=0x0000_0001, shamt=31, mode=00, tag=7, out_ready=1 -> out_valid high exactly 5 cycles after accept, out_data=0x8000_0000, out_tag=7.
- Mode sweep: in_data=0x8000_00F0, shamt=4, back-to-back on consecutive cycles:
  - SLL -> 0x0000_0F00
  - SRL -> 0x0800_000F
  - SRA -> 0xF800_000F
  - ROR -> 0x0800_000F
  - The four results appear on 4 consecutive cycles in issue order.
- Boundary amounts: shamt=0 in all modes -> out_data equals in_data; SRA of 0xFFFF_FFFE with shamt=31 -> 0xFFFF_FFFF; ROR of 0x1234_5678 with shamt=16 -> 0x5678_1234.
- Stall: 5 ops issued, out_ready held low once the first result appears -> in_ready=0, out_data/out_tag stable for 10 cycles; on release all 5 results drain one per cycle in order, none lost or duplicated.
- Flush: 3 ops in flight plus flush=1 with in_valid=1 -> no out_valid for those ops or the flush-cycle input; an op issued the next cycle appears with latency 5.
- Async reset: assert rst between clock edges with the pipeline full -> out_valid=0, out_data=0, out_tag=0 immediately, before the next edge; normal operation resumes after deassert.
